// File: rtl/result_display.sv
// result_display
// Converts a 16-bit unsigned magnitude plus sign into BCD with a serial
// shift-add-3 (double dabble) engine, commits the resulting glyphs atomically
// into a six-digit display register, and time-multiplexes that register onto
// shared seven-segment lines. Digit 5 is the sign position, digit 0 the ones.

module result_display #(
    parameter int unsigned SCAN_DIV = 50000, // cycles each digit stays selected (>= 2)
    parameter bit          CA       = 1'b1   // 1: common-anode, SEG/DIG active-low
) (
    input  logic        clk_i,
    input  logic        reset_i,   // synchronous, active-high
    input  logic        load_i,    // one-cycle capture strobe, honoured only when idle
    input  logic [15:0] result_i,  // magnitude to display
    input  logic        neg_i,     // sign of result_i, 1 = negative
    output logic        busy_o,    // conversion in progress
    output logic        done_o,    // one-cycle pulse when new digits are committed
    output logic [7:0]  seg_o,     // {dp,g,f,e,d,c,b,a}
    output logic [5:0]  dig_o      // one-hot digit select, [0] = ones, [5] = sign
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int unsigned PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRES_MAX = PW'(SCAN_DIV - 1);

    localparam logic [6:0] GLYPH_BLANK = 7'h00;
    localparam logic [6:0] GLYPH_MINUS = 7'h40;
    localparam logic [6:0] GLYPH_ZERO  = 7'h3F;

    // Inactive output levels depend on the display polarity.
    localparam logic [7:0] SEG_OFF = CA ? 8'hFF : 8'h00;
    localparam logic [5:0] DIG_OFF = CA ? 6'h3F : 6'h00;

    // Reset content of the display register: positive zero, only digit 0 lit.
    localparam logic [5:0][6:0] DISP_RESET = {GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK,
                                              GLYPH_BLANK, GLYPH_BLANK, GLYPH_ZERO};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_q;
    logic [15:0]     bin_q;      // binary shift register, MSB shifted into BCD
    logic [19:0]     bcd_q;      // five BCD nibbles, nibble 0 = ones
    logic            neg_q;      // sign latched with the load
    logic [3:0]      iter_q;     // number of shifts already performed
    logic            busy_q;
    logic            done_q;
    logic [5:0][6:0] disp_q;     // active-high glyphs, index = digit position

    logic [PW-1:0]   pres_q;     // scan prescaler
    logic [2:0]      idx_q;      // currently selected digit, 0..5
    logic [7:0]      seg_q;
    logic [5:0]      dig_q;

    // Combinational helpers
    logic [19:0]     bcd_adj;    // BCD after the add-3 correction
    logic [5:0][6:0] disp_d;     // glyph set to commit from the finished BCD
    logic            lead_zero;  // still inside the run of leading zeros
    logic [6:0]      cur_glyph;  // glyph for the selected digit
    logic [5:0]      cur_dig;    // one-hot select for the selected digit

    // Active-high seven-segment glyph for one decimal digit.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = GLYPH_BLANK;
        endcase
    endfunction

    // Add 3 to every BCD nibble that is 5 or more before the next shift.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Build the committed glyph set: leading-zero blanking, ones always shown,
    // minus sign only for a nonzero negative magnitude.
    always_comb begin
        disp_d    = '0;
        lead_zero = 1'b1;
        for (int i = 4; i >= 1; i--) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                lead_zero = 1'b0;
            end
            disp_d[i] = lead_zero ? GLYPH_BLANK : glyph(bcd_q[4*i +: 4]);
        end
        disp_d[0] = glyph(bcd_q[3:0]);
        disp_d[5] = (neg_q && (bcd_q != 20'd0)) ? GLYPH_MINUS : GLYPH_BLANK;
    end

    // Conversion FSM: capture, 16 shift-add-3 steps, then atomic commit.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            // NOTE: the display register is reset explicitly because its reset content is visible on the outputs.
            disp_q  <= DISP_RESET;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load_i) begin
                        bin_q   <= result_i;
                        bcd_q   <= '0;
                        neg_q   <= neg_i;
                        iter_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CONV;
                    end
                end
                S_CONV: begin
                    {bcd_q, bin_q} <= {bcd_adj[18:0], bin_q, 1'b0};
                    iter_q         <= iter_q + 4'd1;
                    if (iter_q == 4'd15) begin
                        state_q <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    disp_q  <= disp_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Select the glyph and one-hot digit strobe for the current scan index.
    always_comb begin
        cur_glyph = GLYPH_BLANK;
        cur_dig   = 6'b00_0001;
        case (idx_q)
            3'd0:    begin cur_glyph = disp_q[0]; cur_dig = 6'b00_0001; end
            3'd1:    begin cur_glyph = disp_q[1]; cur_dig = 6'b00_0010; end
            3'd2:    begin cur_glyph = disp_q[2]; cur_dig = 6'b00_0100; end
            3'd3:    begin cur_glyph = disp_q[3]; cur_dig = 6'b00_1000; end
            3'd4:    begin cur_glyph = disp_q[4]; cur_dig = 6'b01_0000; end
            3'd5:    begin cur_glyph = disp_q[5]; cur_dig = 6'b10_0000; end
            default: begin cur_glyph = GLYPH_BLANK; cur_dig = 6'b00_0001; end
        endcase
    end

    // Free-running scan: prescaler, digit index and registered SEG/DIG drive.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pres_q <= '0;
            idx_q  <= '0;
            seg_q  <= SEG_OFF;
            dig_q  <= DIG_OFF;
        end else begin
            if (pres_q == PRES_MAX) begin
                pres_q <= '0;
                idx_q  <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
            end else begin
                pres_q <= pres_q + 1'b1;
            end
            // dp is never lit; CA flips both buses to active-low.
            seg_q <= CA ? ~{1'b0, cur_glyph} : {1'b0, cur_glyph};
            dig_q <= CA ? ~cur_dig : cur_dig;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign seg_o  = seg_q;
    assign dig_o  = dig_q;

endmodule

// File: tb/tb_result_display.sv
// Testbench for result_display (SCAN_DIV=4, common-anode).
// A cycle-level reference model computes expected BUSY/DONE timing from the
// load acceptance rule and expected SEG/DIG from decimal arithmetic on the
// last committed value, and every cycle is compared against the DUT.

module tb_result_display;

    localparam int SCAN_DIV = 4;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] result;
    logic        neg;
    logic        busy;
    logic        done;
    logic [7:0]  seg;
    logic [5:0]  dig;

    int errors = 0;
    int checks = 0;

    result_display #(
        .SCAN_DIV(SCAN_DIV),
        .CA      (1'b1)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (load),
        .result_i(result),
        .neg_i   (neg),
        .busy_o  (busy),
        .done_o  (done),
        .seg_o   (seg),
        .dig_o   (dig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-high glyphs for decimal digits 0..9.
    logic [7:0] tbl [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                             8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    // Reference model state
    bit m_init    = 1'b0; // a reset has been applied
    bit m_out_off = 1'b1; // outputs forced inactive by reset
    int k         = 0;    // rising edges since the last reset edge
    int m_cnt     = 0;    // remaining busy cycles, 0 = idle
    bit m_done    = 1'b0;
    int pend_v    = 0;
    bit pend_n    = 1'b0;
    int disp_v    = 0;    // committed display value
    bit disp_n    = 1'b0;
    int shown_v   = 0;    // display value feeding the SEG register this cycle
    bit shown_n   = 1'b0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected active-low segment pattern for digit position d of value v.
    function automatic logic [7:0] exp_seg(input int d, input int v, input bit n);
        logic [7:0] g;
        int p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        if (d == 5)                 g = (n && v != 0) ? 8'h40 : 8'h00;
        else if (d == 0 || v >= p)  g = tbl[(v / p) % 10];
        else                        g = 8'h00;
        return ~g;
    endfunction

    // One clock cycle: compare outputs, drive inputs, advance the model.
    task automatic cycle(input bit ld, input int val, input bit ng, input bit rst);
        int         d;
        logic [5:0] e_dig;
        logic [7:0] e_seg;
        @(negedge clk);
        if (m_init) begin
            check("busy", busy, (m_cnt > 0) ? 1'b1 : 1'b0);
            check("done", done, m_done);
            if (m_out_off) begin
                check("seg_rst", seg, 8'hFF);
                check("dig_rst", dig, 6'h3F);
            end else begin
                d     = ((k - 1) / SCAN_DIV) % 6;
                e_dig = ~(6'b00_0001 << d);
                e_seg = exp_seg(d, shown_v, shown_n);
                check("dig", dig, e_dig);
                check("seg", seg, e_seg);
            end
        end
        load   = ld;
        result = val[15:0];
        neg    = ng;
        reset  = rst;
        @(posedge clk);
        if (rst) begin
            m_init    = 1'b1;
            m_out_off = 1'b1;
            k         = 0;
            m_cnt     = 0;
            m_done    = 1'b0;
            disp_v    = 0;
            disp_n    = 1'b0;
            shown_v   = 0;
            shown_n   = 1'b0;
        end else begin
            m_out_off = 1'b0;
            k++;
            shown_v = disp_v;
            shown_n = disp_n;
            m_done  = 1'b0;
            if (m_cnt == 0) begin
                if (ld) begin
                    m_cnt  = 17;
                    pend_v = val & 16'hFFFF;
                    pend_n = ng;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    disp_v = pend_v;
                    disp_n = pend_n;
                    m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b0);
    endtask

    // Load a value, then run long enough to see it committed and fully scanned.
    task automatic load_and_show(input int val, input bit ng);
        cycle(1'b1, val, ng, 1'b0);
        idle(18 + 6 * SCAN_DIV + 2);
    endtask

    function automatic int pick_value();
        case ($urandom_range(0, 11))
            0:       return 0;
            1:       return 7;
            2:       return 9;
            3:       return 10;
            4:       return 99;
            5:       return 100;
            6:       return 9999;
            7:       return 10000;
            8:       return 65535;
            default: return int'($urandom_range(0, 65535));
        endcase
    endfunction

    initial begin
        load   = 1'b0;
        result = '0;
        neg    = 1'b0;
        reset  = 1'b1;

        // Reset and free scan of the reset display content
        cycle(1'b0, 0, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b1);
        idle(6 * SCAN_DIV * 2);

        // Basic load and value boundaries
        load_and_show(12345, 1'b0);
        load_and_show(65535, 1'b1);
        load_and_show(0, 1'b1);
        load_and_show(7, 1'b1);

        // LOAD while busy is ignored; LOAD in the DONE cycle is accepted
        cycle(1'b1, 100, 1'b0, 1'b0);            // cycle 0
        idle(4);                                 // cycles 1..4
        cycle(1'b1, 999, 1'b0, 1'b0);            // cycle 5, ignored
        idle(12);                                // cycles 6..17
        cycle(1'b1, 999, 1'b0, 1'b0);            // cycle 18, DONE cycle
        idle(18 + 6 * SCAN_DIV + 2);

        // Reset in the middle of a conversion
        cycle(1'b1, 4321, 1'b0, 1'b0);           // cycle 0
        idle(7);                                 // cycles 1..7
        cycle(1'b0, 0, 1'b0, 1'b1);              // cycle 8, reset
        idle(6 * SCAN_DIV + 4);
        load_and_show(4321, 1'b0);

        // Randomized traffic with occasional resets and loads while busy
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 9) == 0), pick_value(), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 299) == 0));
        end
        idle(18 + 6 * SCAN_DIV + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
